seq_tx: RTL and testbench

Serial frame transmitter: the sending end of the 3-bit "110" sync-marker serial link. It accepts a parallel word over a valid/ready handshake and drives one serial line with a frame. Each frame is the sync marker 1,1,0, then the payload MSB-first, then an optional even-parity bit. Between frames the line idles at 0. It feeds the serial input of the link's sync detector/receiver; the idle-0 guarantee keeps the marker the first "110" of each frame.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_tx_if.sv | 14 +
 rtl/seq_tx_shreg.sv | 25 ++
 rtl/seq_tx.sv | 99 +++++++++
 tb/tb_seq_tx.sv | 138 +++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the "110" sync-marker serial link (transmitter and receiver).
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    localparam logic [2:0] SYNC_PAT = 3'b110;
    localparam int         SYNC_LEN = 3;

endpackage

// File: rtl/seq_tx_if.sv
// Word handshake plus serial-line outputs of the frame transmitter.
interface seq_tx_if #(
    parameter int W = 8
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         x;
    logic         busy;
    logic         done;

    modport master (output data, output valid, input ready, input x, input busy, input done);
    modport slave  (input data, input valid, output ready, output x, output busy, output done);
endinterface

// File: rtl/seq_tx_shreg.sv
// Loadable W-bit left-shift register; msb is the next payload bit to go out.
module seq_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);
    logic [W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= d;
        end else if (shift) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb = sr_q[W-1];
endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: sync marker 110, payload MSB-first, optional even parity.
//   state | meaning
//   IDLE  | line at 0, ready for a word
//   SYNC  | sending the 3-bit marker
//   DATA  | sending payload bits
//   PAR   | sending the parity bit
module seq_tx
    import seq_pkg::*;
#(
    parameter int W      = 8,
    parameter int PARITY = 1
) (
    input  logic     clk,
    input  logic     rst,
    seq_tx_if.slave  bus
);
    localparam int CW = $clog2((W > SYNC_LEN) ? W : SYNC_LEN);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          x_q, x_d;
    logic          par_q;
    logic          load, shift, msb;

    seq_tx_shreg #(.W(W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .d     (bus.data),
        .msb   (msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            if (load) par_q <= ^bus.data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d = SYNC;
                    cnt_d   = CW'(SYNC_LEN - 1);
                    load    = 1'b1;
                end
            end
            SYNC: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CW'(W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    state_d = (PARITY != 0) ? PAR : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PAR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // x is registered, so it is computed from the state being entered; the
    // shift register advances each time one of its bits is loaded into x.
    always_comb begin
        shift = (state_d == DATA);
        x_d   = 1'b0;
        case (state_d)
            SYNC:    x_d = SYNC_PAT[cnt_d[1:0]];
            DATA:    x_d = msb;
            PAR:     x_d = par_q;
            default: x_d = 1'b0;
        endcase
    end

    assign bus.x     = x_q;
    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == PAR) ||
                       ((state_q == DATA) && (cnt_q == '0) && (PARITY == 0));
endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx (W=8, PARITY=1) against a frame-list reference model.
module tb_seq_tx;
    localparam int W = 8;
    localparam int L = 3 + W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_tx_if #(.W(W)) bus ();

    seq_tx #(.W(W), .PARITY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line contents for one frame: marker, payload MSB-first, even parity.
    function automatic void build_frame(input logic [W-1:0] word, output bit fr[L]);
        int ones = 0;
        fr[0] = 1'b1;
        fr[1] = 1'b1;
        fr[2] = 1'b0;
        for (int i = 0; i < W; i++) begin
            fr[3 + i] = word[W - 1 - i];
            ones += int'(word[W - 1 - i]);
        end
        fr[L - 1] = (ones % 2) == 1;
    endfunction

    // Sends one word and checks every cycle of its frame plus the idle cycle after.
    // hold: leave valid high; chg_cyc/chg_val: rewrite data in that frame cycle;
    // noise: scramble valid/data during the frame (must be ignored).
    task automatic frame(input logic [W-1:0] word, input bit hold, input int chg_cyc,
                         input logic [W-1:0] chg_val, input bit noise);
        bit fr[L];
        build_frame(word, fr);
        bus.data  = word;
        bus.valid = 1'b1;
        step();
        if (!hold) bus.valid = 1'b0;
        for (int n = 1; n <= L; n++) begin
            if (noise) begin
                bus.valid = (n == L) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.data  = W'($urandom);
            end
            if (n == chg_cyc) bus.data = chg_val;
            chk($sformatf("x[%0h].%0d", word, n), 32'(bus.x), 32'(fr[n - 1]));
            chk($sformatf("done[%0h].%0d", word, n), 32'(bus.done), 32'(n == L));
            chk($sformatf("busy[%0h].%0d", word, n), 32'(bus.busy), 32'd1);
            chk($sformatf("ready[%0h].%0d", word, n), 32'(bus.ready), 32'd0);
            step();
        end
        chk("idle_x", 32'(bus.x), 32'd0);
        chk("idle_ready", 32'(bus.ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.data  = '0;
        bus.valid = 1'b0;
        #1;
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("quiet_x", 32'(bus.x), 32'd0);
            chk("quiet_ready", 32'(bus.ready), 32'd1);
            chk("quiet_busy", 32'(bus.busy), 32'd0);
            chk("quiet_done", 32'(bus.done), 32'd0);
        end

        frame(8'hA5, 1'b0, 0, 8'h00, 1'b0);
        frame(8'h07, 1'b0, 0, 8'h00, 1'b0);

        // Back-to-back with valid held: the next word is presented in the done cycle.
        frame(8'hFF, 1'b1, L, 8'h00, 1'b0);
        frame(8'h00, 1'b0, 0, 8'h00, 1'b0);

        // data rewritten mid-payload must not disturb the frame in flight.
        frame(8'hA5, 1'b0, 6, 8'h3C, 1'b0);

        // Reset during cycle 6 of a frame.
        bus.data  = 8'hC3;
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        for (int n = 1; n < 6; n++) step();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_x", 32'(bus.x), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_x", 32'(bus.x), 32'd0);
        chk("post_rst_ready", 32'(bus.ready), 32'd1);
        frame(8'h81, 1'b0, 0, 8'h00, 1'b0);

        for (int k = 0; k < 24; k++) begin
            int gap;
            frame(W'($urandom), 1'b0, 0, 8'h00, 1'b1);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                chk("gap_x", 32'(bus.x), 32'd0);
                chk("gap_ready", 32'(bus.ready), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
